led_anim_engine: RTL and testbench

// Parametrised LED-matrix animation engine: plays one of NANIM keypad-selected

---
 rtl/led_anim_engine.sv | 174 +++++++++++++++++
 tb/tb_led_anim_engine.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/led_anim_engine.sv
// LED-matrix animation engine: plays a keypad-selected animation from an external
// pattern ROM (once, loop or ping-pong) and row-scans the matrix from a tear-free buffer.
`timescale 1ns/1ps
module led_anim_engine #(
    parameter int ROWS      = 8,
    parameter int COLS      = 8,
    parameter int NANIM     = 3,
    parameter int NFRAMES   = 32,
    parameter int FRAME_DIV = 2**23,
    parameter int SCAN_DIV  = 2**14,
    localparam int FW = (NFRAMES > 1) ? $clog2(NFRAMES) : 1,
    localparam int AW = (NANIM > 1) ? $clog2(NANIM) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NANIM-1:0]     sel,
    input  logic [1:0]           mode,
    input  logic [FW-1:0]        frame_last,
    output logic [AW-1:0]        anim_idx,
    output logic [FW-1:0]        frame_idx,
    input  logic [ROWS*COLS-1:0] frame_data,
    output logic [ROWS-1:0]      row,
    output logic [COLS-1:0]      col,
    output logic                 all_on,
    output logic                 done
);

    localparam int PW = $clog2(FRAME_DIV);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {IDLE, PLAY, HOLD} state_t;

    state_t               state_q, state_d;
    logic [NANIM-1:0]     sel_s1, sel_s2;
    logic                 sel_valid, prev_valid, restart;
    logic [AW-1:0]        sel_idx, prev_idx;
    logic                 dir_q, dir_d;
    logic [PW-1:0]        presc_q, presc_d;
    logic [FW-1:0]        frame_d, lastc;
    logic [AW-1:0]        anim_d;
    logic                 tick;
    logic [SW-1:0]        sc_q;
    logic [RW-1:0]        r_q;
    logic                 scan_step, r_last;
    logic [ROWS*COLS-1:0] buffer_q, load_val;
    logic [COLS-1:0]      slice, col_d;

    // Selection synchroniser and lowest-index priority encode
    always_comb begin
        sel_valid = |sel_s2;
        sel_idx   = '0;
        for (int i = NANIM - 1; i >= 0; i--)
            if (sel_s2[i]) sel_idx = AW'(i);
        restart = (sel_valid != prev_valid) || (sel_idx != prev_idx);
    end

    always_comb begin
        if ({1'b0, frame_last} > (FW + 1)'(NFRAMES - 1)) lastc = FW'(NFRAMES - 1);
        else                                            lastc = frame_last;
    end

    assign tick = (state_q == PLAY) && (presc_q == PW'(FRAME_DIV - 1));

    always_comb begin
        state_d = state_q;
        frame_d = frame_idx;
        dir_d   = dir_q;
        presc_d = presc_q;
        anim_d  = anim_idx;
        if (restart) begin
            presc_d = '0;
            frame_d = '0;
            dir_d   = 1'b0;
            anim_d  = sel_idx;
            state_d = sel_valid ? PLAY : IDLE;
        end else if (state_q == PLAY) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
            if (tick) begin
                case (mode)
                    2'd1: frame_d = (frame_idx >= lastc) ? '0 : frame_idx + FW'(1);
                    2'd2: begin
                        // Endpoints are visited once: direction flips on leaving them
                        if (!dir_q) begin
                            if (frame_idx < lastc) frame_d = frame_idx + FW'(1);
                            else if (lastc != '0) begin
                                frame_d = lastc - FW'(1);
                                dir_d   = 1'b1;
                            end else frame_d = '0;
                        end else begin
                            if (frame_idx != '0) frame_d = frame_idx - FW'(1);
                            else if (lastc != '0) begin
                                frame_d = FW'(1);
                                dir_d   = 1'b0;
                            end
                        end
                    end
                    default: begin
                        if (frame_idx < lastc) frame_d = frame_idx + FW'(1);
                        else begin
                            frame_d = lastc;
                            state_d = HOLD;
                        end
                    end
                endcase
            end
        end else begin
            presc_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel_s1     <= '0;
            sel_s2     <= '0;
            prev_valid <= 1'b0;
            prev_idx   <= '0;
            state_q    <= IDLE;
            dir_q      <= 1'b0;
            presc_q    <= '0;
            frame_idx  <= '0;
            anim_idx   <= '0;
        end else begin
            sel_s1     <= sel;
            sel_s2     <= sel_s1;
            prev_valid <= sel_valid;
            prev_idx   <= sel_idx;
            state_q    <= state_d;
            dir_q      <= dir_d;
            presc_q    <= presc_d;
            frame_idx  <= frame_d;
            anim_idx   <= anim_d;
        end
    end

    assign done = (state_q == IDLE) || (state_q == HOLD);

    // Row scan and display buffer
    assign scan_step = (sc_q == SW'(SCAN_DIV - 1));
    assign r_last    = (r_q == RW'(ROWS - 1));
    assign load_val  = (state_q == IDLE) ? '0 : frame_data;

    always_comb begin
        slice = buffer_q[(ROWS * COLS - 1) - int'(r_q) * COLS -: COLS];
        for (int k = 0; k < COLS; k++)
            col_d[k] = ~slice[COLS - 1 - k];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sc_q     <= '0;
            r_q      <= '0;
            buffer_q <= '0;
            all_on   <= 1'b0;
            row      <= '1;
            col      <= '1;
        end else begin
            if (scan_step) begin
                sc_q <= '0;
                r_q  <= r_last ? '0 : r_q + RW'(1);
                // The buffer only changes as the scan returns to row 0
                if (r_last) begin
                    buffer_q <= load_val;
                    all_on   <= (load_val == '1);
                end
            end else begin
                sc_q <= sc_q + SW'(1);
            end
            row <= ~(ROWS'(1) << r_q);
            col <= col_d;
        end
    end

endmodule

// File: tb/tb_led_anim_engine.sv
// Bench for led_anim_engine: directed and randomized playback runs compared with a
// frame-sequence model, plus scan/display checks against a pixel-level model.
`timescale 1ns/1ps
module tb_led_anim_engine;

    localparam int ROWS = 4, COLS = 4, NANIM = 3, NFRAMES = 8;
    localparam int FRAME_DIV = 16, SCAN_DIV = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  sel = 3'b000;
    logic [1:0]  mode = 2'd0;
    logic [2:0]  frame_last = 3'd0;
    logic [1:0]  anim_idx;
    logic [2:0]  frame_idx;
    logic [15:0] frame_data;
    logic [3:0]  row, col;
    logic        all_on, done;

    logic [15:0] rom [4][8];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign frame_data = rom[anim_idx][frame_idx];

    led_anim_engine #(
        .ROWS(ROWS), .COLS(COLS), .NANIM(NANIM), .NFRAMES(NFRAMES),
        .FRAME_DIV(FRAME_DIV), .SCAN_DIV(SCAN_DIV)
    ) dut (
        .clk(clk), .reset(reset), .sel(sel), .mode(mode), .frame_last(frame_last),
        .anim_idx(anim_idx), .frame_idx(frame_idx), .frame_data(frame_data),
        .row(row), .col(col), .all_on(all_on), .done(done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame shown during the k-th frame period after a restart
    function automatic int exp_frame(input int m, input int last, input int k);
        int pos;
        if (m == 1) return k % (last + 1);
        if (m == 2) begin
            if (last == 0) return 0;
            pos = k % (2 * last);
            return (pos <= last) ? pos : 2 * last - pos;
        end
        return (k < last) ? k : last;
    endfunction

    // Pixel (r,k) is bit 15-4r-k of the pattern; a lit pixel pulls its column low
    function automatic logic [3:0] exp_col(input logic [15:0] pix, input int r);
        logic [3:0] c;
        for (int k = 0; k < COLS; k++) c[k] = ~pix[15 - COLS * r - k];
        return c;
    endfunction

    function automatic int low_idx(input logic [2:0] s);
        for (int i = 0; i < NANIM; i++) if (s[i]) return i;
        return 0;
    endfunction

    task automatic go_idle();
        sel = 3'b000;
        repeat (6) tick();
    endtask

    task automatic play_run(input logic [2:0] s, input int m, input int last, input int n);
        go_idle();
        mode       = m[1:0];
        frame_last = last[2:0];
        sel        = s;
        repeat (3) tick();
        check("start_anim", anim_idx, low_idx(s));
        check("start_frame", frame_idx, 0);
        check("start_done", done, 0);
        for (int k = 0; k < n; k++) begin
            repeat ((k == 0) ? 8 : 16) tick();
            check("frame_idx", frame_idx, exp_frame(m, last, k));
            check("play_done", done, ((m == 0 || m == 3) && k > last) ? 1 : 0);
        end
    endtask

    task automatic wait_row(input int r);
        bit ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (row === ~(4'b0001 << r)) ok = 1;
            else tick();
        end
        check("row_reached", ok, 1);
    endtask

    task automatic check_display(input logic [15:0] pix);
        for (int r = 0; r < ROWS; r++) begin
            wait_row(r);
            check("col", col, exp_col(pix, r));
        end
        check("all_on", all_on, (pix == 16'hFFFF) ? 1 : 0);
    endtask

    initial begin
        logic [2:0]  s;
        logic [15:0] pa, pb;
        for (int a = 0; a < 4; a++)
            for (int f = 0; f < 8; f++) rom[a][f] = 16'($urandom);

        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_row", row, 4'hF);
        check("rst_col", col, 4'hF);
        check("rst_done", done, 1);
        check("rst_all_on", all_on, 0);
        check("rst_frame", frame_idx, 0);
        check("rst_anim", anim_idx, 0);
        reset = 1'b1;
        tick();

        // Directed playback sequences
        play_run(3'b001, 0, 3, 6);
        play_run(3'b001, 1, 2, 7);
        play_run(3'b001, 2, 3, 9);
        play_run(3'b100, 2, 0, 3);

        // Randomized playback
        for (int i = 0; i < 8; i++) begin
            play_run(3'($urandom_range(1, 7)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 7)), 10);
        end

        // Display mapping on a held single frame
        rom[0][0] = 16'h8000;
        play_run(3'b001, 0, 0, 2);
        wait_row(0);
        check("row0_drive", row, 4'b1110);
        check("col_8000", col, 4'b1110);
        check_display(16'h8000);
        rom[0][0] = 16'hFFFF;
        repeat (20) tick();
        check_display(16'hFFFF);
        check("col_ffff", col, 4'h0);

        // Frame data changed mid-scan stays off the matrix until the row-0 load
        pa = 16'($urandom);
        pb = ~pa;
        rom[0][0] = pa;
        repeat (20) tick();
        wait_row(2);
        rom[0][0] = pb;
        wait_row(3);
        check("midscan_old", col, exp_col(pa, 3));
        wait_row(0);
        check("midscan_new", col, exp_col(pb, 0));
        check_display(pb);

        // Random pattern on a random selection
        s = 3'($urandom_range(1, 7));
        pa = 16'($urandom);
        rom[low_idx(s)][0] = pa;
        play_run(s, 3, 0, 2);
        repeat (10) tick();
        check_display(pa);

        // Deselect blanks the matrix
        sel = 3'b000;
        repeat (3) tick();
        check("blank_done", done, 1);
        repeat (20) tick();
        check_display(16'h0000);

        // Switching animation mid-play
        play_run(3'b001, 1, 2, 3);
        sel = 3'b010;
        repeat (2) tick();
        check("switch_lat_anim", anim_idx, 0);
        check("switch_lat_frame", frame_idx, 2);
        tick();
        check("switch_anim", anim_idx, 1);
        check("switch_frame", frame_idx, 0);
        check("switch_done", done, 0);
        repeat (16) tick();
        check("switch_next", frame_idx, 1);

        // Asynchronous reset mid-play
        play_run(3'b001, 1, 3, 3);
        #2 reset = 1'b0;
        #1;
        check("areset_row", row, 4'hF);
        check("areset_col", col, 4'hF);
        check("areset_done", done, 1);
        check("areset_frame", frame_idx, 0);
        #2 reset = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
